ide_sector_ctl: RTL and testbench

Sector-level sequencer that sits above the word-level `ide` cycle engine and drives its `ata_rd`/`ata_wr`/`ata_addr`/`ata_in` request interface. On a single start pulse it performs a complete ATA PIO LBA28 one-sector READ SECTORS (0x20) or WRITE SECTORS (0x30) transaction:
- status polling,
- task-file programming,
- 256 data-word transfers,
- completion check.

Data moves to or from a 256×16 sector buffer owned by the host side (PDP-8 disk interface).

---
 rtl/ide_sector_ctl_if.sv | 32 +++
 rtl/ide_sector_ctl.sv | 229 ++++++++++++++++++++++
 tb/tb_ide_sector_ctl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ide_sector_ctl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ide_sector_ctl_if                                      |
// | Description : Request bus toward the word-level ide engine plus the  |
// |               host-side 256x16 sector buffer port.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface ide_sector_ctl_if;
  // ide request side
  logic        ata_rd;
  logic        ata_wr;
  logic [4:0]  ata_addr;
  logic [15:0] ata_in;
  logic [15:0] ata_out;
  logic        ata_done;
  // sector buffer side
  logic [7:0]  buf_addr;
  logic        buf_we;
  logic [15:0] buf_wdata;
  logic [15:0] buf_rdata;

  modport master (
    output ata_rd, ata_wr, ata_addr, ata_in, buf_addr, buf_we, buf_wdata,
    input  ata_out, ata_done, buf_rdata
  );

  modport slave (
    input  ata_rd, ata_wr, ata_addr, ata_in, buf_addr, buf_we, buf_wdata,
    output ata_out, ata_done, buf_rdata
  );
endinterface
`default_nettype wire

// File: rtl/ide_sector_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ide_sector_ctl                                         |
// | Description : ATA PIO LBA28 single-sector READ/WRITE sequencer that  |
// |               drives the ide cycle engine and the sector buffer.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ide_sector_ctl #(
  parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             write,
  input  logic [27:0]      lba,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  ide_sector_ctl_if.master bus
);

  // Task-file map: data 10000, sector count 10010 .. status/command 10111.
  // The six SET_REGS targets are consecutive, so they are A_SCNT + step.
  localparam logic [4:0] A_DATA = 5'b10000;
  localparam logic [4:0] A_SCNT = 5'b10010;
  localparam logic [4:0] A_STAT = 5'b10111;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_SET_REGS, S_WAIT_DRQ,
    S_XFER, S_WAIT_END, S_FAIL,     S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        dir_wr_q, dir_wr_d;
  logic [27:0] lba_q, lba_d;
  logic [2:0]  step_q, step_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] poll_q, poll_d;
  logic        error_q, error_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        ata_rd_q, ata_rd_d;
  logic        ata_wr_q, ata_wr_d;
  logic [4:0]  ata_addr_q, ata_addr_d;
  logic [15:0] ata_in_q, ata_in_d;
  logic [7:0]  buf_addr_q, buf_addr_d;
  logic        buf_we_q, buf_we_d;
  logic [15:0] buf_wdata_q, buf_wdata_d;

  logic        req_idle;
  logic        poll_hit;
  logic        st_bsy, st_drq, st_err;
  logic [7:0]  reg_byte;

  // Next-state and access sequencing; a request is launched whenever none is
  // outstanding, which yields exactly one idle cycle after each ata_done.
  always_comb begin
    state_d     = state_q;
    dir_wr_d    = dir_wr_q;
    lba_d       = lba_q;
    step_d      = step_q;
    idx_d       = idx_q;
    poll_d      = poll_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
    ata_rd_d    = ata_rd_q;
    ata_wr_d    = ata_wr_q;
    ata_addr_d  = ata_addr_q;
    ata_in_d    = ata_in_q;
    buf_addr_d  = buf_addr_q;
    buf_we_d    = 1'b0;
    buf_wdata_d = buf_wdata_q;

    req_idle = !ata_rd_q && !ata_wr_q;
    poll_hit = (poll_q + 16'd1) == POLL_MAX;
    st_bsy   = bus.ata_out[7];
    st_drq   = bus.ata_out[3];
    st_err   = bus.ata_out[0];

    case (step_q)
      3'd0:    reg_byte = 8'h01;
      3'd1:    reg_byte = lba_q[7:0];
      3'd2:    reg_byte = lba_q[15:8];
      3'd3:    reg_byte = lba_q[23:16];
      3'd4:    reg_byte = {4'hE, lba_q[27:24]};
      default: reg_byte = dir_wr_q ? 8'h30 : 8'h20;
    endcase

    // Read words advance the buffer address right after their write strobe.
    if (buf_we_q) buf_addr_d = buf_addr_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_wr_d   = write;
          lba_d      = lba;
          error_d    = 1'b0;
          err_code_d = 2'b00;
          poll_d     = 16'd0;
          step_d     = 3'd0;
          idx_d      = 8'd0;
          buf_addr_d = 8'd0;
          state_d    = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY, S_WAIT_DRQ, S_WAIT_END: begin
        if (req_idle) begin
          ata_rd_d   = 1'b1;
          ata_addr_d = A_STAT;
        end else if (bus.ata_done) begin
          ata_rd_d = 1'b0;
          poll_d   = poll_q + 16'd1;
          if (state_q == S_WAIT_RDY && !st_bsy) begin
            step_d  = 3'd0;
            state_d = S_SET_REGS;
          end else if (state_q == S_WAIT_DRQ && !st_bsy && st_drq) begin
            idx_d   = 8'd0;
            state_d = S_XFER;
          end else if (state_q != S_WAIT_RDY && !st_bsy && st_err) begin
            err_code_d = 2'b01;
            state_d    = S_FAIL;
          end else if (state_q == S_WAIT_END && !st_bsy) begin
            state_d = S_DONE;
          end else if (poll_hit) begin
            err_code_d = 2'b10;
            state_d    = S_FAIL;
          end
        end
      end
      S_SET_REGS: begin
        if (req_idle) begin
          ata_wr_d   = 1'b1;
          ata_addr_d = A_SCNT + {2'b00, step_q};
          ata_in_d   = {8'h00, reg_byte};
        end else if (bus.ata_done) begin
          ata_wr_d = 1'b0;
          step_d   = step_q + 3'd1;
          if (step_q == 3'd5) begin
            poll_d  = 16'd0;
            state_d = S_WAIT_DRQ;
          end
        end
      end
      S_XFER: begin
        if (req_idle) begin
          ata_addr_d = A_DATA;
          if (dir_wr_q) begin
            // buf_rdata already holds the word at buf_addr; move the buffer
            // on so the next word is ready by the following idle cycle.
            ata_wr_d   = 1'b1;
            ata_in_d   = bus.buf_rdata;
            buf_addr_d = buf_addr_q + 8'd1;
          end else begin
            ata_rd_d = 1'b1;
          end
        end else if (bus.ata_done) begin
          ata_rd_d = 1'b0;
          ata_wr_d = 1'b0;
          idx_d    = idx_q + 8'd1;
          if (!dir_wr_q) begin
            buf_we_d    = 1'b1;
            buf_wdata_d = bus.ata_out;
          end
          if (idx_q == 8'hFF) begin
            poll_d  = 16'd0;
            state_d = S_WAIT_END;
          end
        end
      end
      S_FAIL: begin
        error_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      dir_wr_q    <= 1'b0;
      lba_q       <= 28'd0;
      step_q      <= 3'd0;
      idx_q       <= 8'd0;
      poll_q      <= 16'd0;
      error_q     <= 1'b0;
      err_code_q  <= 2'b00;
      ata_rd_q    <= 1'b0;
      ata_wr_q    <= 1'b0;
      ata_addr_q  <= 5'b11111;
      ata_in_q    <= 16'd0;
      buf_addr_q  <= 8'd0;
      buf_we_q    <= 1'b0;
      buf_wdata_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      dir_wr_q    <= dir_wr_d;
      lba_q       <= lba_d;
      step_q      <= step_d;
      idx_q       <= idx_d;
      poll_q      <= poll_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      ata_rd_q    <= ata_rd_d;
      ata_wr_q    <= ata_wr_d;
      ata_addr_q  <= ata_addr_d;
      ata_in_q    <= ata_in_d;
      buf_addr_q  <= buf_addr_d;
      buf_we_q    <= buf_we_d;
      buf_wdata_q <= buf_wdata_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign error         = error_q;
  assign err_code      = err_code_q;
  assign bus.ata_rd    = ata_rd_q;
  assign bus.ata_wr    = ata_wr_q;
  assign bus.ata_addr  = ata_addr_q;
  assign bus.ata_in    = ata_in_q;
  assign bus.buf_addr  = buf_addr_q;
  assign bus.buf_we    = buf_we_q;
  assign bus.buf_wdata = buf_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ide_sector_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ide_sector_ctl                                      |
// | Description : Scoreboard bench for ide_sector_ctl with an ide engine |
// |               responder and a synchronous sector buffer model.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_ide_sector_ctl;
  localparam logic [4:0] A_DATA = 5'b10000;
  localparam logic [4:0] A_STAT = 5'b10111;
  // Busy cycles of a transaction with one status read per poll phase:
  // 265 accesses of 6 cycles plus the DONE cycle.
  localparam int BUSY_MIN = 6 * 265 + 1;
  localparam logic [52:0] RST_SNAP = {8'h00, 5'b11111, 40'h0};

  logic        clk = 1'b0;
  logic        reset_n, start, write, sel, ata_done;
  logic [27:0] lba;
  logic [15:0] ata_out, buf_rdata;
  logic [15:0] mem [256];
  int          checks = 0;
  int          errors = 0;
  logic [27:0] exp_q [$];

  // responder controls and observations
  int          rdy_busy_left = 0;
  bit          stuck_bsy = 1'b0;
  logic [7:0]  drq_stat = 8'h58;
  int          phase = 0;
  int          dcount = 0;
  int          stat_cnt [3];

  always #5 clk = ~clk;

  ide_sector_ctl_if bus_a ();
  ide_sector_ctl_if bus_b ();

  logic       busy_a, done_a, error_a, busy_b, done_b, error_b;
  logic [1:0] code_a, code_b;
  logic       start_a, start_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  ide_sector_ctl dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .write(write), .lba(lba),
    .busy(busy_a), .done(done_a), .error(error_a), .err_code(code_a), .bus(bus_a)
  );

  ide_sector_ctl #(.POLL_MAX(16'd4)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .write(write), .lba(lba),
    .busy(busy_b), .done(done_b), .error(error_b), .err_code(code_b), .bus(bus_b)
  );

  assign bus_a.ata_out   = ata_out;
  assign bus_b.ata_out   = ata_out;
  assign bus_a.ata_done  = ata_done & ~sel;
  assign bus_b.ata_done  = ata_done & sel;
  assign bus_a.buf_rdata = buf_rdata;
  assign bus_b.buf_rdata = buf_rdata;

  // view of whichever instance is under test
  logic        m_rd, m_wr, m_we, m_busy, m_done, m_error;
  logic [1:0]  m_code;
  logic [4:0]  m_addr;
  logic [7:0]  m_baddr;
  logic [15:0] m_in, m_wdata;
  assign m_rd    = sel ? bus_b.ata_rd    : bus_a.ata_rd;
  assign m_wr    = sel ? bus_b.ata_wr    : bus_a.ata_wr;
  assign m_we    = sel ? bus_b.buf_we    : bus_a.buf_we;
  assign m_addr  = sel ? bus_b.ata_addr  : bus_a.ata_addr;
  assign m_baddr = sel ? bus_b.buf_addr  : bus_a.buf_addr;
  assign m_in    = sel ? bus_b.ata_in    : bus_a.ata_in;
  assign m_wdata = sel ? bus_b.buf_wdata : bus_a.buf_wdata;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_done  = sel ? done_b  : done_a;
  assign m_error = sel ? error_b : error_a;
  assign m_code  = sel ? code_b  : code_a;

  // synchronous sector buffer read port
  always @(posedge clk) buf_rdata <= mem[m_baddr];

  function automatic logic [15:0] rd_word(input int i);
    return 16'(i * 257) ^ 16'h5A3C;
  endfunction

  function automatic logic [52:0] snap();
    return {m_busy, m_done, m_error, m_code, m_we, m_rd, m_wr,
            m_addr, m_baddr, m_wdata, m_in};
  endfunction

  // ide engine responder: ata_done in the 5th cycle of a request
  initial begin : ide_model
    int cnt;
    cnt = 0;
    ata_done = 1'b0;
    ata_out = 16'h0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        ata_done = 1'b0; cnt = 0; phase = 0;
      end else if (ata_done) begin
        ata_done = 1'b0; cnt = 0;
      end else if (m_rd || m_wr) begin
        if (cnt == 4) begin
          ata_done = 1'b1;
          if (m_rd && m_addr == A_STAT) begin
            stat_cnt[phase]++;
            if (phase == 0) begin
              if (stuck_bsy || rdy_busy_left > 0) ata_out = 16'h0080;
              else ata_out = 16'h0050;
              if (rdy_busy_left > 0) rdy_busy_left--;
            end else if (phase == 1) ata_out = {8'h00, drq_stat};
            else ata_out = 16'h0050;
          end else if (m_addr == A_DATA) begin
            if (m_rd) ata_out = rd_word(dcount);
            dcount++;
            phase = 2;
          end else if (m_wr && m_addr == A_STAT) begin
            phase = 1;
          end
        end else cnt++;
      end
    end
  end

  // scoreboard: every request launch and buffer write is popped and compared
  initial begin : monitor
    logic prev;
    logic [27:0] ev, ex;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if ((m_rd || m_wr) && !prev) begin
        ev = {m_wr ? 4'h2 : 4'h1, 3'b000, m_addr, m_wr ? m_in : 16'h0000};
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL sb_access: got %h expected none", ev);
        end else begin
          ex = exp_q.pop_front();
          if (ev !== ex) begin errors++; $display("FAIL sb_access: got %h expected %h", ev, ex); end
        end
      end
      if (m_we) begin
        ev = {4'h3, m_baddr, m_wdata};
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL sb_buffer: got %h expected none", ev);
        end else begin
          ex = exp_q.pop_front();
          if (ev !== ex) begin errors++; $display("FAIL sb_buffer: got %h expected %h", ev, ex); end
        end
      end
      prev = m_rd || m_wr;
    end
  end

  task automatic prep();
    phase = 0; dcount = 0;
    stat_cnt = '{0, 0, 0};
    exp_q.delete();
  endtask

  task automatic push_stat(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({4'h1, 3'b000, A_STAT, 16'h0000});
  endtask

  task automatic push_regs(input logic wr, input logic [27:0] l);
    logic [4:0] a [6];
    logic [7:0] b [6];
    a = '{5'b10010, 5'b10011, 5'b10100, 5'b10101, 5'b10110, 5'b10111};
    b = '{8'h01, l[7:0], l[15:8], l[23:16], {4'hE, l[27:24]}, wr ? 8'h30 : 8'h20};
    for (int i = 0; i < 6; i++) exp_q.push_back({4'h2, 3'b000, a[i], 8'h00, b[i]});
  endtask

  task automatic push_data(input logic wr);
    for (int i = 0; i < 256; i++) begin
      if (wr) exp_q.push_back({4'h2, 3'b000, A_DATA, mem[i]});
      else begin
        exp_q.push_back({4'h1, 3'b000, A_DATA, 16'h0000});
        exp_q.push_back({4'h3, 8'(i), rd_word(i)});
      end
    end
  endtask

  task automatic push_full(input logic wr, input logic [27:0] l, input int rdy_polls);
    push_stat(rdy_polls); push_regs(wr, l); push_stat(1); push_data(wr); push_stat(1);
  endtask

  // Pulse start and wait (bounded) for done; inputs are scrambled after the
  // pulse so only captured values can produce the expected task file.
  task automatic run_txn(input logic wr, input logic [27:0] l, output bit got,
                         output int cyc, output logic [2:0] ec, output logic err_first);
    got = 1'b0; cyc = 0; ec = 3'b000;
    @(negedge clk); start = 1'b1; write = wr; lba = l;
    @(negedge clk); start = 1'b0; write = ~wr; lba = ~l;
    err_first = m_error;
    for (int i = 0; i < 5000 && !got; i++) begin
      if (m_busy) cyc++;
      if (m_done) begin got = 1'b1; ec = {m_error, m_code}; end
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; write = 1'b0; lba = 28'h0; sel = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (snap() !== RST_SNAP) begin errors++; $display("FAIL reset_a: got %h expected %h", snap(), RST_SNAP); end
    sel = 1'b1;
    #1;
    checks++;
    if (snap() !== RST_SNAP) begin errors++; $display("FAIL reset_b: got %h expected %h", snap(), RST_SNAP); end
    sel = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read();
    bit got; int cyc; logic [2:0] ec; logic ef;
    prep(); push_full(1'b0, 28'h0123456, 1);
    run_txn(1'b0, 28'h0123456, got, cyc, ec, ef);
    checks++; if (!got) begin errors++; $display("FAIL read_done: got 0 expected 1"); end
    checks++; if (ec !== 3'b000) begin errors++; $display("FAIL read_err: got %b expected 000", ec); end
    checks++; if (cyc != BUSY_MIN) begin errors++; $display("FAIL read_cycles: got %0d expected %0d", cyc, BUSY_MIN); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL read_pending: got %0d expected 0", exp_q.size()); end
    @(negedge clk);
    checks++; if ({m_busy, m_done} !== 2'b00) begin errors++; $display("FAIL read_busy_after: got %b expected 00", {m_busy, m_done}); end
  endtask

  task automatic test_write();
    bit got; int cyc; logic [2:0] ec; logic ef;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i) ^ 16'hA5A5;
    prep(); push_full(1'b1, 28'hFFFFFFF, 1);
    run_txn(1'b1, 28'hFFFFFFF, got, cyc, ec, ef);
    checks++; if (!got) begin errors++; $display("FAIL write_done: got 0 expected 1"); end
    checks++; if (ec !== 3'b000) begin errors++; $display("FAIL write_err: got %b expected 000", ec); end
    checks++; if (cyc != BUSY_MIN) begin errors++; $display("FAIL write_cycles: got %0d expected %0d", cyc, BUSY_MIN); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL write_pending: got %0d expected 0", exp_q.size()); end
    checks++; if (m_baddr !== 8'h00) begin errors++; $display("FAIL write_addr_wrap: got %h expected 00", m_baddr); end
  endtask

  task automatic test_bsy_poll();
    bit got; int cyc; logic [2:0] ec; logic ef;
    prep(); rdy_busy_left = 10; push_full(1'b0, 28'hABCDEF1, 11);
    run_txn(1'b0, 28'hABCDEF1, got, cyc, ec, ef);
    checks++; if (!got || ec !== 3'b000) begin errors++; $display("FAIL bsy_done: got %0d/%b expected 1/000", got, ec); end
    checks++; if (stat_cnt[0] != 11) begin errors++; $display("FAIL bsy_polls: got %0d expected 11", stat_cnt[0]); end
    checks++; if (cyc != BUSY_MIN + 60) begin errors++; $display("FAIL bsy_cycles: got %0d expected %0d", cyc, BUSY_MIN + 60); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bsy_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_drq_err();
    bit got; int cyc; logic [2:0] ec; logic ef;
    prep(); drq_stat = 8'h51;
    push_stat(1); push_regs(1'b0, 28'h0000777); push_stat(1);
    run_txn(1'b0, 28'h0000777, got, cyc, ec, ef);
    drq_stat = 8'h58;
    checks++; if (!got || ec !== 3'b101) begin errors++; $display("FAIL drq_err: got %0d/%b expected 1/101", got, ec); end
    checks++; if (dcount != 0) begin errors++; $display("FAIL drq_data: got %0d expected 0", dcount); end
    checks++; if (stat_cnt[1] != 1) begin errors++; $display("FAIL drq_polls: got %0d expected 1", stat_cnt[1]); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drq_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    bit got; int cyc; logic [2:0] ec; logic ef;
    sel = 1'b1;
    prep(); stuck_bsy = 1'b1; push_stat(4);
    run_txn(1'b0, 28'h0000042, got, cyc, ec, ef);
    stuck_bsy = 1'b0;
    checks++; if (!got || ec !== 3'b110) begin errors++; $display("FAIL to_err: got %0d/%b expected 1/110", got, ec); end
    checks++; if (stat_cnt[0] != 4) begin errors++; $display("FAIL to_polls: got %0d expected 4", stat_cnt[0]); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL to_pending: got %0d expected 0", exp_q.size()); end
    repeat (2) @(negedge clk);
    prep(); push_full(1'b0, 28'h0000042, 1);
    run_txn(1'b0, 28'h0000042, got, cyc, ec, ef);
    checks++; if (ef !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b expected 0", ef); end
    checks++; if (!got || ec !== 3'b000) begin errors++; $display("FAIL to_restart: got %0d/%b expected 1/000", got, ec); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL to_restart_pending: got %0d expected 0", exp_q.size()); end
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit got, hit; int cyc; logic [2:0] ec; logic ef, last_rd;
    prep(); push_full(1'b0, 28'h5555555, 1);
    @(negedge clk); start = 1'b1; write = 1'b0; lba = 28'h5555555;
    @(negedge clk); start = 1'b0;
    hit = 1'b0; last_rd = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      if (dcount == 100 && m_rd && !last_rd) hit = 1'b1;
      else begin last_rd = m_rd; @(negedge clk); end
    end
    checks++; if (!hit) begin errors++; $display("FAIL mid_reach_word100: got 0 expected 1"); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (snap() !== RST_SNAP) begin errors++; $display("FAIL mid_reset: got %h expected %h", snap(), RST_SNAP); end
    exp_q.delete();
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    prep(); push_full(1'b1, 28'h0ACE123, 1);
    run_txn(1'b1, 28'h0ACE123, got, cyc, ec, ef);
    checks++; if (!got || ec !== 3'b000) begin errors++; $display("FAIL mid_restart: got %0d/%b expected 1/000", got, ec); end
    checks++; if (cyc != BUSY_MIN) begin errors++; $display("FAIL mid_cycles: got %0d expected %0d", cyc, BUSY_MIN); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_pending: got %0d expected 0", exp_q.size()); end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    stat_cnt = '{0, 0, 0};
    test_reset();
    test_read();
    test_write();
    test_bsy_poll();
    test_drq_err();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
